// File: rtl/forward_ew_arb_if.sv
// Handshake bundle for forward_ew_arb: merged source FIFO heads in,
// three output FIFO heads with empty flags and occupancy counts out.
interface forward_ew_arb_if #(
   parameter int PACKET_WIDTH = 30,
   parameter int NUM_IN       = 2,
   parameter int NW           = 21,
   parameter int CW           = 3
);
   logic [NUM_IN*PACKET_WIDTH-1:0] din;
   logic [NUM_IN-1:0]              empty_in;
   logic [NUM_IN-1:0]              ren_out;
   logic                           ren_in_routing;
   logic                           ren_in_north;
   logic                           ren_in_south;
   logic [PACKET_WIDTH-1:0]        dout_routing;
   logic [NW-1:0]                  dout_north;
   logic [NW-1:0]                  dout_south;
   logic                           routing_buffer_empty;
   logic                           north_buffer_empty;
   logic                           south_buffer_empty;
   logic [CW-1:0]                  routing_count;
   logic [CW-1:0]                  north_count;
   logic [CW-1:0]                  south_count;

   modport master (
      output din, empty_in, ren_in_routing, ren_in_north, ren_in_south,
      input  ren_out, dout_routing, dout_north, dout_south,
             routing_buffer_empty, north_buffer_empty, south_buffer_empty,
             routing_count, north_count, south_count
   );

   modport slave (
      input  din, empty_in, ren_in_routing, ren_in_north, ren_in_south,
      output ren_out, dout_routing, dout_north, dout_south,
             routing_buffer_empty, north_buffer_empty, south_buffer_empty,
             routing_count, north_count, south_count
   );
endinterface

// File: rtl/forward_ew_arb.sv
// East/west forwarding stage: round-robin merge of NUM_IN source FIFOs, dx/dy
// decode, and three independent output FIFOs (routing, north, south).
module forward_ew_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wen,
   input  logic [WIDTH-1:0] wdata,
   input  logic             ren,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_rd;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      do_rd   = ren && (count_q != '0);
      if (wen) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_rd) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (wen && !do_rd) begin
         count_d = count_q + CW'(1);
      end else if (!wen && do_rd) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign rdata = mem_q[rptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
endmodule

module forward_ew_arb #(
   parameter int PACKET_WIDTH = 30,
   parameter int DX_MSB       = 29,
   parameter int DX_LSB       = 21,
   parameter int DY_MSB       = 20,
   parameter int DY_LSB       = 12,
   parameter int BUFFER_DEPTH = 4,
   parameter int EAST         = 1,
   parameter int NUM_IN       = 2,
   parameter int NW           = PACKET_WIDTH - (DX_MSB - DY_MSB),
   parameter int CW           = $clog2(BUFFER_DEPTH) + 1
) (
   input logic              clk,
   input logic              reset_n,
   forward_ew_arb_if.slave  bus
);
   localparam int DXW = DX_MSB - DX_LSB + 1;
   localparam int DYW = DY_MSB - DY_LSB + 1;
   localparam int IW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   typedef enum logic [1:0] {DEST_ROUTE, DEST_NORTH, DEST_SOUTH} dest_e;

   logic [PACKET_WIDTH-1:0] head     [NUM_IN];
   logic [PACKET_WIDTH-1:0] fwd_word [NUM_IN];
   logic signed [DXW-1:0]   dx       [NUM_IN];
   logic signed [DYW-1:0]   dy       [NUM_IN];
   dest_e                   dest     [NUM_IN];
   logic [NUM_IN-1:0]       elig;

   logic [IW-1:0]           ptr_q, ptr_d;
   logic                    grant_vld;
   logic [IW-1:0]           grant_idx;
   logic [NUM_IN-1:0]       ren_vec;
   logic [PACKET_WIDTH-1:0] win_word;
   logic                    wen_r, wen_n, wen_s;
   logic                    r_full, n_full, s_full;

   function automatic logic signed [DXW-1:0] step_dx(input logic signed [DXW-1:0] d);
      logic signed [DXW-1:0] one;
      one = DXW'(1);
      return (EAST != 0) ? (d - one) : (d + one);
   endfunction

   // Full flags come straight from the registered counts, so a downstream
   // read only re-enables its destination on the following cycle.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         head[i]     = bus.din[i*PACKET_WIDTH +: PACKET_WIDTH];
         dx[i]       = head[i][DX_MSB:DX_LSB];
         dy[i]       = head[i][DY_MSB:DY_LSB];
         fwd_word[i] = head[i];
         if (dx[i] != '0) begin
            dest[i]                     = DEST_ROUTE;
            fwd_word[i][DX_MSB:DX_LSB]  = step_dx(dx[i]);
         end else if (dy[i] < 0) begin
            dest[i] = DEST_SOUTH;
         end else begin
            dest[i] = DEST_NORTH;
         end
         elig[i] = reset_n && !bus.empty_in[i] &&
                   !((dest[i] == DEST_ROUTE && r_full) ||
                     (dest[i] == DEST_NORTH && n_full) ||
                     (dest[i] == DEST_SOUTH && s_full));
      end
   end

   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = (int'(ptr_q) + k) % NUM_IN;
         if (!grant_vld && elig[idx]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_vld) begin
         ptr_d = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + IW'(1);
      end
   end

   always_comb begin
      ren_vec  = '0;
      wen_r    = 1'b0;
      wen_n    = 1'b0;
      wen_s    = 1'b0;
      win_word = fwd_word[grant_idx];
      if (grant_vld) begin
         ren_vec[grant_idx] = 1'b1;
         case (dest[grant_idx])
            DEST_ROUTE: wen_r = 1'b1;
            DEST_NORTH: wen_n = 1'b1;
            default:    wen_s = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign bus.ren_out = ren_vec;

   forward_ew_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH), .CW(CW)) u_routing (
      .clk(clk), .reset_n(reset_n),
      .wen(wen_r), .wdata(win_word), .ren(bus.ren_in_routing),
      .rdata(bus.dout_routing), .empty(bus.routing_buffer_empty),
      .full(r_full), .count(bus.routing_count)
   );

   forward_ew_fifo #(.WIDTH(NW), .DEPTH(BUFFER_DEPTH), .CW(CW)) u_north (
      .clk(clk), .reset_n(reset_n),
      .wen(wen_n), .wdata(win_word[NW-1:0]), .ren(bus.ren_in_north),
      .rdata(bus.dout_north), .empty(bus.north_buffer_empty),
      .full(n_full), .count(bus.north_count)
   );

   forward_ew_fifo #(.WIDTH(NW), .DEPTH(BUFFER_DEPTH), .CW(CW)) u_south (
      .clk(clk), .reset_n(reset_n),
      .wen(wen_s), .wdata(win_word[NW-1:0]), .ren(bus.ren_in_south),
      .rdata(bus.dout_south), .empty(bus.south_buffer_empty),
      .full(s_full), .count(bus.south_count)
   );
endmodule

// File: doc/forward_ew_arb.md
# forward_ew_arb

Parametrised east/west forwarding stage for the router mesh. It merges `NUM_IN` upstream FIFO sources with a round-robin arbiter and decodes each packet's dx/dy offsets. Each packet goes to one of three output FIFOs: continue-routing, north or south. Unlike the fixed two-input forwarder, a full output stalls only the packets headed for that output, and occupancy counts are exported for each output buffer.

## Interface
- `PACKET_WIDTH`, 30: full packet width.
- `DX_MSB`, 29: MSB of the signed dx field.
- `DX_LSB`, 21: LSB of dx. Must equal `DY_MSB+1`.
- `DY_MSB`, 20: MSB of the signed dy field.
- `DY_LSB`, 12: LSB of dy.
- `BUFFER_DEPTH`, 4: depth of each output FIFO. Must be a power of 2, ≥2.
- `EAST`, 1: direction select. 1 = forward east (dx step −1); 0 = forward west (dx step +1).
- `NUM_IN`, 2: number of merged sources, 1..8.
- Derived widths: `NW = PACKET_WIDTH-(DX_MSB-DY_MSB)`; `CW = $clog2(BUFFER_DEPTH)+1`.
- `clk`  in  1  the single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  NUM_IN*PACKET_WIDTH  head word of each source FIFO. Source i occupies slice `[i*PACKET_WIDTH +: PACKET_WIDTH]`. First-word-fall-through: valid whenever the matching `empty_in` bit is 0.
- `empty_in`  in  NUM_IN  per-source empty flags.
- `ren_out`  out  NUM_IN  one-hot-or-zero pop strobe to the sources.
- `ren_in_routing`, `ren_in_north`, `ren_in_south`  in  1 each  downstream pop strobes.
- `dout_routing`  out  PACKET_WIDTH  head of the routing FIFO.
- `dout_north`, `dout_south`  out  NW each  head of the north/south FIFOs.
- `routing_buffer_empty`, `north_buffer_empty`, `south_buffer_empty`  out  1 each  empty flags.
- `routing_count`, `north_count`, `south_count`  out  CW each  current FIFO occupancy.

## Operation
- **Decode** (combinational, per source head):
  - dx ≠ 0: destination is routing. The packet is forwarded with dx replaced by `dx + ADD` mod 2^(DX width), where ADD = −1 if `EAST` else +1. All other bits pass through unchanged.
  - dx = 0, dy sign bit = 0 (dy ≥ 0): destination is north. The payload is `packet[NW-1:0]`, i.e. the dx field is stripped.
  - dx = 0, dy sign bit = 1: destination is south, with the same stripping.
- **Eligibility:** source i is eligible when `empty_in[i]=0` and its decoded destination FIFO is not full.
  - Full is evaluated before any same-cycle downstream read.
- **Round-robin arbiter:**
  - Holds pointer `ptr` (reset 0).
  - Grants the first eligible index scanning ptr, ptr+1, … with wrap modulo NUM_IN.
  - On a grant, `ptr` ← grant+1 mod NUM_IN. With no grant, `ptr` is unchanged.
- **Grant effects:** `ren_out[g]=1` combinationally. At the same clock edge the decoded word is written into its destination FIFO. At most one write per cycle in total.
- **Output FIFOs:**
  - Circular buffers with read and write pointers and an occupancy counter.
  - Simultaneous read and write on a non-empty FIFO leaves the count unchanged.
  - A read while empty is ignored.
  - A write while full cannot occur by construction.
  - Each count equals the number of stored words, range 0..BUFFER_DEPTH.
- Packets from a given source leave in source order within each destination. Packets going to different destinations are unordered relative to each other.

## Timing
- **Reset values** (async, immediate):
  - all FIFOs empty; `*_empty`=1; counts 0; `ptr`=0; storage cleared, so `dout_*`=0.
  - `ren_out`=0 while `reset_n` is low, regardless of `empty_in`.
- **Reset mid-operation:** all stored packets are discarded. The first grant is possible in the first cycle after release.
- **Latency:** a packet popped at edge t has `*_empty` low and data on `dout_*` after edge t.
- **Throughput:** 1 packet/cycle aggregate. A destination whose FIFO is full blocks only the sources whose head targets it.
- **Full FIFO:** a downstream read at edge t frees a slot. Eligibility for that FIFO returns in the cycle after t, not the same cycle.

## Test plan
1. **Routing with dx update:** EAST=1; source 0 head dx=3, dy=0 → `ren_out`=01. One cycle later `routing_buffer_empty`=0, `dout_routing` dx=2 with all other bits identical, `routing_count`=1.
2. **North/south strip:** dx=0, dy=0x1FE (−2) → `south_count`=1 and `dout_south` = packet[20:0]. dx=0, dy=0x001 → lands in north.
3. **Fairness and full:** both sources always non-empty, all packets bound for routing, no downstream reads → grants 0,1,0,1. After 4 writes `routing_count`=4 and `ren_out`=00. A single `ren_in_routing` pulse → exactly one further grant, to source 0.
4. **Per-destination backpressure:** north FIFO full; source 0 head goes north, source 1 stream goes south → source 1 is granted every cycle and `ren_out[0]` stays 0. Draining north → source 0 is granted within 2 cycles.
5. **dx wrap:** EAST=1, dx=0x100 → forwarded dx=0x0FF. EAST=0, dx=0x1FF → forwarded dx=0x000, still routed to the routing FIFO.
6. **Reset mid-operation:** 3 packets queued, drop `reset_n` mid-cycle → all empties 1, counts 0, `ren_out`=00 immediately. After release, fresh traffic behaves as in test 1.
